// File: rtl/riscv_mc_pkg.sv
// Encodings shared by the multi-cycle RV32I control FSM and the datapath it steers.
package riscv_mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD, S_MEM_WR, S_MEM_WB,
      S_ALU_WB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_AUIPC, S_TRAP
   } state_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [1:0] SRC_A_PC     = 2'b00;
   localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
   localparam logic [1:0] SRC_A_RS1    = 2'b10;

   localparam logic [1:0] SRC_B_RS2  = 2'b00;
   localparam logic [1:0] SRC_B_IMM  = 2'b01;
   localparam logic [1:0] SRC_B_FOUR = 2'b10;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_U = 3'd3;
   localparam logic [2:0] IMM_J = 3'd4;

   localparam logic [1:0] WB_ALU  = 2'b00;
   localparam logic [1:0] WB_MEM  = 2'b01;
   localparam logic [1:0] WB_LINK = 2'b10;

   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_SUB  = 2'b01;
   localparam logic [1:0] ALU_FUNC = 2'b10;

   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

   // Execute state chosen from the opcode; anything unrecognised traps.
   function automatic state_e decode_state(input logic [6:0] opcode);
      case (opcode)
         OP_REG:    return S_EXEC_R;
         OP_IMM:    return S_EXEC_I;
         OP_LOAD:   return S_MEM_ADDR;
         OP_STORE:  return S_MEM_ADDR;
         OP_BRANCH: return S_BRANCH;
         OP_JAL:    return S_JAL;
         OP_JALR:   return S_JALR;
         OP_LUI:    return S_LUI;
         OP_AUIPC:  return S_AUIPC;
         default:   return S_TRAP;
      endcase
   endfunction

endpackage

// File: rtl/riscv_mc_wait_timer.sv
// Memory wait counter: counts stalled cycles in a memory state and flags when the limit is reached.
module riscv_mc_wait_timer #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (clear_i) begin
         cnt_q <= '0;
      end else if (en_i && !expired_o) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expired_o = (cnt_q == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle RV32I control unit: sequences fetch/decode/execute/mem/writeback over one memory port.
module riscv_mc_ctrl
   import riscv_mc_pkg::*;
#(
   parameter int unsigned DW          = 32,
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [DW-1:0]    inst_i,
   input  logic             br_taken_i,
   input  logic             mem_ready_i,
   output logic             mem_req_o,
   output logic             mem_we_o,
   output logic             mem_iord_o,
   output logic             pc_write_o,
   output logic             ir_write_o,
   output logic             reg_write_o,
   output logic [1:0]       alu_src_a_o,
   output logic [1:0]       alu_src_b_o,
   output logic [2:0]       imm_src_o,
   output logic [1:0]       wb_sel_o,
   output logic [1:0]       alu_op_o,
   output logic             trap_o,
   output logic [1:0]       trap_cause_o,
   output logic [CNT_W-1:0] cycle_cnt_o,
   output logic [CNT_W-1:0] instret_o
);

   state_e           state_q, state_d;
   logic [1:0]       cause_q, cause_d;
   logic [CNT_W-1:0] cycle_q, instret_q;
   logic             mem_wait, timer_clear, timer_expired, retire;
   logic [6:0]       opcode;
   logic             inst_unused;

   assign opcode      = inst_i[6:0];
   assign inst_unused = ^inst_i[DW-1:7];

   riscv_mc_wait_timer #(
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) u_wait_timer (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clear_i   (timer_clear),
      .en_i      (mem_wait),
      .expired_o (timer_expired)
   );

   assign timer_clear = (state_d != state_q);
   assign retire      = (state_q != S_FETCH) && (state_d == S_FETCH);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_FETCH;
         cause_q   <= CAUSE_NONE;
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         cycle_q <= cycle_q + 1'b1;
         if (retire) begin
            instret_q <= instret_q + 1'b1;
         end
      end
   end

   // Outputs are also gated by rst_i so a request dropped mid-wait falls at once, not at the next edge.
   always_comb begin
      state_d     = state_q;
      cause_d     = cause_q;
      mem_wait    = 1'b0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_iord_o  = 1'b0;
      pc_write_o  = 1'b0;
      ir_write_o  = 1'b0;
      reg_write_o = 1'b0;
      alu_src_a_o = SRC_A_PC;
      alu_src_b_o = SRC_B_RS2;
      imm_src_o   = IMM_I;
      wb_sel_o    = WB_ALU;
      alu_op_o    = ALU_ADD;
      if (!rst_i) begin
         case (state_q)
            S_FETCH: begin
               mem_wait    = 1'b1;
               mem_req_o   = 1'b1;
               alu_src_b_o = SRC_B_FOUR;
               if (mem_ready_i) begin
                  ir_write_o = 1'b1;
                  pc_write_o = 1'b1;
                  state_d    = S_DECODE;
               end else if (timer_expired) begin
                  state_d = S_TRAP;
                  cause_d = CAUSE_TIMEOUT;
               end
            end
            S_DECODE: begin
               alu_src_a_o = SRC_A_OLD_PC;
               alu_src_b_o = SRC_B_IMM;
               imm_src_o   = IMM_B;
               state_d     = decode_state(opcode);
               if (decode_state(opcode) == S_TRAP) begin
                  cause_d = CAUSE_ILLEGAL;
               end
            end
            S_EXEC_R: begin
               alu_op_o    = ALU_FUNC;
               alu_src_a_o = SRC_A_RS1;
               alu_src_b_o = SRC_B_RS2;
               state_d     = S_ALU_WB;
            end
            S_EXEC_I: begin
               alu_op_o    = ALU_FUNC;
               alu_src_a_o = SRC_A_RS1;
               alu_src_b_o = SRC_B_IMM;
               imm_src_o   = IMM_I;
               state_d     = S_ALU_WB;
            end
            S_LUI: begin
               alu_op_o    = ALU_FUNC;
               alu_src_a_o = SRC_A_RS1;
               alu_src_b_o = SRC_B_IMM;
               imm_src_o   = IMM_U;
               state_d     = S_ALU_WB;
            end
            S_AUIPC: begin
               alu_src_a_o = SRC_A_OLD_PC;
               alu_src_b_o = SRC_B_IMM;
               imm_src_o   = IMM_U;
               state_d     = S_ALU_WB;
            end
            S_ALU_WB: begin
               reg_write_o = 1'b1;
               wb_sel_o    = WB_ALU;
               state_d     = S_FETCH;
            end
            S_MEM_ADDR: begin
               alu_src_a_o = SRC_A_RS1;
               alu_src_b_o = SRC_B_IMM;
               imm_src_o   = (opcode == OP_STORE) ? IMM_S : IMM_I;
               state_d     = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
               mem_wait   = 1'b1;
               mem_req_o  = 1'b1;
               mem_iord_o = 1'b1;
               if (mem_ready_i) begin
                  state_d = S_MEM_WB;
               end else if (timer_expired) begin
                  state_d = S_TRAP;
                  cause_d = CAUSE_TIMEOUT;
               end
            end
            S_MEM_WB: begin
               reg_write_o = 1'b1;
               wb_sel_o    = WB_MEM;
               state_d     = S_FETCH;
            end
            S_MEM_WR: begin
               mem_wait   = 1'b1;
               mem_req_o  = 1'b1;
               mem_we_o   = 1'b1;
               mem_iord_o = 1'b1;
               if (mem_ready_i) begin
                  state_d = S_FETCH;
               end else if (timer_expired) begin
                  state_d = S_TRAP;
                  cause_d = CAUSE_TIMEOUT;
               end
            end
            S_BRANCH: begin
               alu_op_o    = ALU_SUB;
               alu_src_a_o = SRC_A_RS1;
               alu_src_b_o = SRC_B_RS2;
               pc_write_o  = br_taken_i;
               state_d     = S_FETCH;
            end
            S_JAL: begin
               alu_src_a_o = SRC_A_OLD_PC;
               alu_src_b_o = SRC_B_IMM;
               imm_src_o   = IMM_J;
               reg_write_o = 1'b1;
               wb_sel_o    = WB_LINK;
               pc_write_o  = 1'b1;
               state_d     = S_FETCH;
            end
            S_JALR: begin
               // Datapath clears bit 0 of the rs1+imm target.
               alu_src_a_o = SRC_A_RS1;
               alu_src_b_o = SRC_B_IMM;
               imm_src_o   = IMM_I;
               reg_write_o = 1'b1;
               wb_sel_o    = WB_LINK;
               pc_write_o  = 1'b1;
               state_d     = S_FETCH;
            end
            S_TRAP: begin
               state_d = S_TRAP;
            end
            default: begin
               state_d = S_FETCH;
            end
         endcase
      end
   end

   assign trap_o       = (state_q == S_TRAP);
   assign trap_cause_o = cause_q;
   assign cycle_cnt_o  = cycle_q;
   assign instret_o    = instret_q;

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Self-checking bench for riscv_mc_ctrl: directed scenarios plus randomized instruction stream vs a CPI model.
module tb_riscv_mc_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] inst_i;
   logic        br_taken_i;
   logic        mem_ready_i;
   logic        mem_req_o, mem_we_o, mem_iord_o;
   logic        pc_write_o, ir_write_o, reg_write_o;
   logic [1:0]  alu_src_a_o, alu_src_b_o, wb_sel_o, alu_op_o, trap_cause_o;
   logic [2:0]  imm_src_o;
   logic        trap_o;
   logic [31:0] cycle_cnt_o, instret_o;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   always #5 clk_i = ~clk_i;

   riscv_mc_ctrl #(
      .DW(32),
      .CNT_W(32),
      .MEM_TIMEOUT(16)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .inst_i       (inst_i),
      .br_taken_i   (br_taken_i),
      .mem_ready_i  (mem_ready_i),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_iord_o   (mem_iord_o),
      .pc_write_o   (pc_write_o),
      .ir_write_o   (ir_write_o),
      .reg_write_o  (reg_write_o),
      .alu_src_a_o  (alu_src_a_o),
      .alu_src_b_o  (alu_src_b_o),
      .imm_src_o    (imm_src_o),
      .wb_sel_o     (wb_sel_o),
      .alu_op_o     (alu_op_o),
      .trap_o       (trap_o),
      .trap_cause_o (trap_cause_o),
      .cycle_cnt_o  (cycle_cnt_o),
      .instret_o    (instret_o)
   );

   // Per-instruction observations gathered by run_instr.
   int unsigned obs_cycles, obs_rw, obs_rw_at, obs_pcw, obs_pcw_at, obs_freq, obs_dreq, obs_we;
   logic [1:0]  obs_wb;
   logic        obs_done;
   logic [31:0] start_instret, start_cycle;

   typedef struct {
      int unsigned cycles;
      int unsigned rw;
      logic [1:0]  wb;
      int unsigned pcw;
      int unsigned dreq;
      int unsigned we;
   } exp_t;

   // Instruction classes: 0 R, 1 I, 2 load, 3 store, 4 branch, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC.
   function automatic logic [6:0] op_of(input int unsigned cls);
      case (cls)
         0: return 7'b0110011;
         1: return 7'b0010011;
         2: return 7'b0000011;
         3: return 7'b0100011;
         4: return 7'b1100011;
         5: return 7'b1101111;
         6: return 7'b1100111;
         7: return 7'b0110111;
         default: return 7'b0010111;
      endcase
   endfunction

   function automatic exp_t model(input int unsigned cls, input int unsigned fw,
                                  input int unsigned mw, input logic taken);
      exp_t e;
      e.cycles = (cls == 2) ? 5 : (cls == 4 || cls == 5 || cls == 6) ? 3 : 4;
      e.cycles = e.cycles + fw + ((cls == 2 || cls == 3) ? mw : 0);
      e.rw     = (cls == 3 || cls == 4) ? 0 : 1;
      e.wb     = (cls == 2) ? 2'b01 : (cls == 5 || cls == 6) ? 2'b10 : 2'b00;
      e.pcw    = 1 + ((cls == 5 || cls == 6) ? 1 : 0) + ((cls == 4 && taken) ? 1 : 0);
      e.dreq   = (cls == 2 || cls == 3) ? mw + 1 : 0;
      e.we     = (cls == 3) ? mw + 1 : 0;
      return e;
   endfunction

   function automatic logic [19:0] all_outs();
      return {mem_req_o, mem_we_o, mem_iord_o, pc_write_o, ir_write_o, reg_write_o, alu_src_a_o,
              alu_src_b_o, imm_src_o, wb_sel_o, alu_op_o, trap_o, trap_cause_o};
   endfunction

   task automatic do_reset();
      rst_i       = 1'b1;
      mem_ready_i = 1'b0;
      br_taken_i  = 1'b0;
      inst_i      = '0;
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
   endtask

   // Memory responder: grants after fw (fetch) or mw (data) stalled cycles; random ready while idle.
   task automatic run_instr(input logic [31:0] inst, input int unsigned fw, input int unsigned mw,
                            input logic taken);
      int unsigned waited;
      obs_cycles = 0; obs_rw = 0; obs_rw_at = 0; obs_pcw = 0; obs_pcw_at = 0;
      obs_freq = 0; obs_dreq = 0; obs_we = 0; obs_wb = 2'b11; obs_done = 1'b0;
      start_instret = instret_o;
      start_cycle   = cycle_cnt_o;
      inst_i        = inst;
      br_taken_i    = taken;
      waited        = 0;
      for (int unsigned c = 0; c < 64 && !obs_done; c++) begin
         if (mem_req_o) mem_ready_i = (waited == (mem_iord_o ? mw : fw));
         else mem_ready_i = 1'($urandom_range(0, 1));
         @(negedge clk_i);
         obs_cycles++;
         if (reg_write_o) begin obs_rw++; obs_wb = wb_sel_o; obs_rw_at = obs_cycles; end
         if (pc_write_o) begin obs_pcw++; obs_pcw_at = obs_cycles; end
         if (mem_req_o && !mem_iord_o) obs_freq++;
         if (mem_req_o && mem_iord_o) obs_dreq++;
         if (mem_req_o && mem_we_o) obs_we++;
         if (mem_req_o) waited = mem_ready_i ? 0 : waited + 1;
         @(posedge clk_i);
         #1;
         if (instret_o != start_instret || trap_o) obs_done = 1'b1;
      end
      mem_ready_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1; mem_ready_i = 1'b1; br_taken_i = 1'b1; inst_i = 32'h0000_0013;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      n_cmp++;
      if (all_outs() !== 20'h0) begin
         n_err++; $display("FAIL reset_outs got %h want %h", all_outs(), 20'h0);
      end
      n_cmp++;
      if (cycle_cnt_o !== 32'd0 || instret_o !== 32'd0) begin
         n_err++; $display("FAIL reset_cnt got %0d/%0d want 0/0", cycle_cnt_o, instret_o);
      end
      @(posedge clk_i);
      #1 rst_i = 1'b0; mem_ready_i = 1'b0; br_taken_i = 1'b0;
      @(negedge clk_i);
      n_cmp++;
      if ({mem_req_o, mem_iord_o, mem_we_o} !== 3'b100) begin
         n_err++; $display("FAIL reset_fetch got %b want 100", {mem_req_o, mem_iord_o, mem_we_o});
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_addi();
      run_instr(32'h0050_0093, 0, 0, 1'b0);
      n_cmp++;
      if (obs_cycles !== 4 || !obs_done) begin
         n_err++; $display("FAIL addi_cycles got %0d want 4", obs_cycles);
      end
      n_cmp++;
      if (obs_rw_at !== 4 || obs_rw !== 1) begin
         n_err++; $display("FAIL addi_regwrite got at=%0d n=%0d want at=4 n=1", obs_rw_at, obs_rw);
      end
      n_cmp++;
      if (instret_o !== start_instret + 32'd1) begin
         n_err++; $display("FAIL addi_instret got %0d want %0d", instret_o, start_instret + 32'd1);
      end
   endtask

   task automatic test_lw();
      run_instr(32'h0000_A103, 0, 3, 1'b0);
      n_cmp++;
      if (obs_cycles !== 8) begin
         n_err++; $display("FAIL lw_cycles got %0d want 8", obs_cycles);
      end
      n_cmp++;
      if (obs_wb !== 2'b01 || obs_dreq !== 4 || obs_we !== 0) begin
         n_err++; $display("FAIL lw_mem got wb=%b dreq=%0d we=%0d want wb=01 dreq=4 we=0",
                           obs_wb, obs_dreq, obs_we);
      end
   endtask

   task automatic test_beq();
      run_instr(32'h0000_0063, 0, 0, 1'b1);
      n_cmp++;
      if (obs_cycles !== 3 || obs_pcw !== 2 || obs_pcw_at !== 3) begin
         n_err++; $display("FAIL beq_taken got cyc=%0d pcw=%0d at=%0d want 3/2/3",
                           obs_cycles, obs_pcw, obs_pcw_at);
      end
      run_instr(32'h0000_0063, 0, 0, 1'b0);
      n_cmp++;
      if (obs_cycles !== 3 || obs_pcw !== 1 || obs_rw !== 0) begin
         n_err++; $display("FAIL beq_not_taken got cyc=%0d pcw=%0d rw=%0d want 3/1/0",
                           obs_cycles, obs_pcw, obs_rw);
      end
   endtask

   task automatic test_random();
      exp_t        e;
      int unsigned cls, fw, mw;
      logic        taken;
      for (int unsigned i = 0; i < 40; i++) begin
         cls   = $urandom_range(0, 8);
         fw    = $urandom_range(0, 4);
         mw    = $urandom_range(0, 4);
         taken = 1'($urandom_range(0, 1));
         e     = model(cls, fw, mw, taken);
         run_instr({25'($urandom), op_of(cls)}, fw, mw, taken);
         n_cmp++;
         if (!obs_done || trap_o) begin
            n_err++; $display("FAIL rnd_done cls=%0d got done=%b trap=%b want 1/0", cls, obs_done, trap_o);
         end
         n_cmp++;
         if (obs_cycles !== e.cycles) begin
            n_err++; $display("FAIL rnd_cycles cls=%0d got %0d want %0d", cls, obs_cycles, e.cycles);
         end
         n_cmp++;
         if (obs_rw !== e.rw || (e.rw == 1 && obs_wb !== e.wb)) begin
            n_err++; $display("FAIL rnd_wb cls=%0d got rw=%0d wb=%b want rw=%0d wb=%b",
                              cls, obs_rw, obs_wb, e.rw, e.wb);
         end
         n_cmp++;
         if (obs_pcw !== e.pcw) begin
            n_err++; $display("FAIL rnd_pcw cls=%0d got %0d want %0d", cls, obs_pcw, e.pcw);
         end
         n_cmp++;
         if (obs_freq !== fw + 1 || obs_dreq !== e.dreq || obs_we !== e.we) begin
            n_err++; $display("FAIL rnd_req cls=%0d got f=%0d d=%0d we=%0d want f=%0d d=%0d we=%0d",
                              cls, obs_freq, obs_dreq, obs_we, fw + 1, e.dreq, e.we);
         end
         n_cmp++;
         if (instret_o !== start_instret + 32'd1 || cycle_cnt_o !== start_cycle + e.cycles) begin
            n_err++; $display("FAIL rnd_counters cls=%0d got ir=%0d cc=%0d want ir=%0d cc=%0d", cls,
                              instret_o, cycle_cnt_o, start_instret + 32'd1, start_cycle + e.cycles);
         end
      end
   endtask

   task automatic test_illegal();
      int unsigned bad;
      logic [31:0] cyc0;
      run_instr({25'($urandom), 7'h7F}, 1, 0, 1'b0);
      n_cmp++;
      if (trap_o !== 1'b1 || trap_cause_o !== 2'd1 || obs_cycles !== 3) begin
         n_err++; $display("FAIL illegal_trap got trap=%b cause=%0d cyc=%0d want 1/1/3",
                           trap_o, trap_cause_o, obs_cycles);
      end
      n_cmp++;
      if (instret_o !== start_instret) begin
         n_err++; $display("FAIL illegal_instret got %0d want %0d", instret_o, start_instret);
      end
      bad  = 0;
      cyc0 = cycle_cnt_o;
      for (int unsigned c = 0; c < 10; c++) begin
         mem_ready_i = 1'($urandom_range(0, 1));
         @(negedge clk_i);
         if (mem_req_o || pc_write_o || ir_write_o || reg_write_o || !trap_o) bad++;
         @(posedge clk_i);
         #1;
      end
      mem_ready_i = 1'b0;
      n_cmp++;
      if (bad !== 0 || cycle_cnt_o !== cyc0 + 32'd10) begin
         n_err++; $display("FAIL trap_absorb got bad=%0d cc=%0d want 0/%0d", bad, cycle_cnt_o, cyc0 + 32'd10);
      end
   endtask

   task automatic test_timeout();
      int unsigned nreq;
      logic        seen;
      do_reset();
      nreq = 0;
      seen = 1'b0;
      for (int unsigned c = 0; c < 40 && !seen; c++) begin
         @(negedge clk_i);
         if (trap_o) seen = 1'b1;
         else if (mem_req_o) nreq++;
      end
      n_cmp++;
      if (!seen || nreq !== 16 || trap_cause_o !== 2'd2) begin
         n_err++; $display("FAIL timeout got seen=%b req=%0d cause=%0d want 1/16/2", seen, nreq, trap_cause_o);
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset_mid();
      do_reset();
      inst_i      = 32'h0000_A103;
      mem_ready_i = 1'b1;
      @(posedge clk_i);
      #1 mem_ready_i = 1'b0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      n_cmp++;
      if ({mem_req_o, mem_iord_o, mem_we_o} !== 3'b110) begin
         n_err++; $display("FAIL mid_wait got %b want 110", {mem_req_o, mem_iord_o, mem_we_o});
      end
      #2 rst_i = 1'b1;
      #1;
      n_cmp++;
      if (all_outs() !== 20'h0 || cycle_cnt_o !== 32'd0 || instret_o !== 32'd0) begin
         n_err++; $display("FAIL mid_async_reset got outs=%h cc=%0d ir=%0d want 0/0/0",
                           all_outs(), cycle_cnt_o, instret_o);
      end
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      n_cmp++;
      if ({mem_req_o, mem_iord_o, mem_we_o, trap_o} !== 4'b1000) begin
         n_err++; $display("FAIL mid_refetch got %b want 1000", {mem_req_o, mem_iord_o, mem_we_o, trap_o});
      end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_lw();
      test_beq();
      test_random();
      test_illegal();
      test_timeout();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
